// File: rtl/message_checker.sv
// message_checker: scans MSG_LEN bytes of d_mem and reports whether all are lowercase a-z or space.
// Define CHECKER_EARLY_EXIT_EN to end the scan right after the first illegal byte.
module message_checker #(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_flag,
    output logic [7:0] address,
    input  logic [7:0] d_data_out,
    output logic       done_flag,
    output logic       valid_flag,
    output logic [7:0] bad_addr
);

    typedef enum logic [2:0] {
        IDLE,
        SET_ADDR,
        WAIT_ADDR,
        CHECK,
        NEXT,
        DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] k;
    logic       scan_ok;
    logic [7:0] scan_bad;
    logic       byte_legal;
    logic       last_byte;
    logic       stop_scan;

    assign byte_legal = ((d_data_out >= 8'h61) && (d_data_out <= 8'h7A)) || (d_data_out == 8'h20);
    assign last_byte  = (k == LAST_IDX);

`ifdef CHECKER_EARLY_EXIT_EN
    assign stop_scan = last_byte || !scan_ok;
`else
    assign stop_scan = last_byte;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start_flag) state_next = SET_ADDR;
            SET_ADDR:  state_next = WAIT_ADDR;
            WAIT_ADDR: state_next = CHECK;
            CHECK:     state_next = NEXT;
            NEXT:      state_next = stop_scan ? DONE : SET_ADDR;
            DONE:      if (!start_flag) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    assign done_flag = (state == DONE);

    // scan_ok/scan_bad track the scan in flight; the visible results only change when the scan ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k          <= 8'h00;
            address    <= 8'h00;
            scan_ok    <= 1'b1;
            scan_bad   <= 8'hFF;
            valid_flag <= 1'b0;
            bad_addr   <= 8'hFF;
        end else begin
            case (state)
                IDLE: begin
                    k <= 8'h00;
                    if (start_flag) begin
                        scan_ok  <= 1'b1;
                        scan_bad <= 8'hFF;
                    end
                end
                SET_ADDR: address <= k;
                CHECK: begin
                    if (!byte_legal && scan_ok) begin
                        scan_ok  <= 1'b0;
                        scan_bad <= k;
                    end
                end
                NEXT: begin
                    if (stop_scan) begin
                        valid_flag <= scan_ok;
                        bad_addr   <= scan_bad;
                    end else begin
                        k <= k + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_message_checker.sv
// Directed self-checking bench for message_checker: MSG_LEN=32 and MSG_LEN=1 instances with registered-output RAM models.
module tb_message_checker;

    localparam int EDGE_LIMIT = 300;

`ifdef CHECKER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_flag;
    logic       start1;
    logic [7:0] address;
    logic [7:0] d_data_out;
    logic       done_flag;
    logic       valid_flag;
    logic [7:0] bad_addr;
    logic [7:0] address1;
    logic [7:0] d_data_out1;
    logic       done_flag1;
    logic       valid_flag1;
    logic [7:0] bad_addr1;

    logic [7:0] mem  [0:255];
    logic [7:0] mem1 [0:255];
    logic [7:0] addr_at_edge [0:EDGE_LIMIT];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        d_data_out  <= mem[address];
        d_data_out1 <= mem1[address1];
    end

    message_checker #(.MSG_LEN(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_flag (start_flag),
        .address    (address),
        .d_data_out (d_data_out),
        .done_flag  (done_flag),
        .valid_flag (valid_flag),
        .bad_addr   (bad_addr)
    );

    message_checker #(.MSG_LEN(1)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_flag (start1),
        .address    (address1),
        .d_data_out (d_data_out1),
        .done_flag  (done_flag1),
        .valid_flag (valid_flag1),
        .bad_addr   (bad_addr1)
    );

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    // Edge 1 is the first posedge that sees start_flag high; done_edge stays -1 if the bound expires.
    task automatic scan_once(input bit hold, output int done_edge);
        start_flag = 1'b0;
        repeat (2) @(negedge clk);
        start_flag = 1'b1;
        done_edge = -1;
        for (int e = 1; e <= EDGE_LIMIT; e++) begin
            @(posedge clk);
            #1;
            addr_at_edge[e] = address;
            if (e == 1 && !hold) start_flag = 1'b0;
            if (done_flag) begin
                done_edge = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        start_flag = 1'b0;
        start1     = 1'b0;
        fill_mem(8'h61);
        for (int i = 0; i < 256; i++) mem1[i] = 8'h61;
        #12;
        tests_run++;
        if (done_flag !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_done: got %b expected 0", done_flag);
        end
        tests_run++;
        if (address !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_address: got %h expected 00", address);
        end
        tests_run++;
        if (valid_flag !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %b expected 0", valid_flag);
        end
        tests_run++;
        if (bad_addr !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL reset_bad_addr: got %h expected ff", bad_addr);
        end
        tests_run++;
        if (done_flag1 !== 1'b0 || valid_flag1 !== 1'b0 || bad_addr1 !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL reset_len1: got done=%b valid=%b bad=%h expected 0 0 ff",
                     done_flag1, valid_flag1, bad_addr1);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_all_legal();
        int de;
        int errs;
        fill_mem(8'h61);
        scan_once(1'b0, de);
        tests_run++;
        if (de !== 129) begin
            tests_failed++;
            $display("[TB] FAIL legal_done_edge: got %0d expected 129", de);
        end
        tests_run++;
        if (valid_flag !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL legal_valid: got %b expected 1", valid_flag);
        end
        tests_run++;
        if (bad_addr !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL legal_bad_addr: got %h expected ff", bad_addr);
        end
        errs = 0;
        for (int k = 0; k < 32; k++)
            for (int j = 2; j <= 5; j++)
                if (addr_at_edge[4 * k + j] !== 8'(k)) errs++;
        tests_run++;
        if (errs !== 0) begin
            tests_failed++;
            $display("[TB] FAIL legal_address_steps: got %0d wrong samples expected 0", errs);
        end
    endtask

    task automatic test_bad_byte5();
        int de;
        int exp_edge;
        fill_mem(8'h20);
        mem[5] = 8'h41;
        exp_edge = EARLY ? 25 : 129;
        scan_once(1'b0, de);
        tests_run++;
        if (de !== exp_edge) begin
            tests_failed++;
            $display("[TB] FAIL byte5_done_edge: got %0d expected %0d", de, exp_edge);
        end
        tests_run++;
        if (valid_flag !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL byte5_valid: got %b expected 0", valid_flag);
        end
        tests_run++;
        if (bad_addr !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL byte5_bad_addr: got %h expected 05", bad_addr);
        end
    endtask

    task automatic test_boundary_chars();
        logic [7:0] pat [5][5];
        logic [7:0] exp_bad [5];
        logic       exp_valid [5];
        int         early_edge [5];
        int         de;
        int         exp_edge;
        pat[0] = '{8'h61, 8'h7A, 8'h20, 8'h60, 8'h7B};
        pat[1] = '{8'h61, 8'h7A, 8'h20, 8'h61, 8'h7B};
        pat[2] = '{8'h61, 8'h7A, 8'h20, 8'h00, 8'hFF};
        pat[3] = '{8'h20, 8'h7A, 8'h61, 8'h20, 8'h61};
        pat[4] = '{8'h61, 8'h61, 8'h61, 8'h61, 8'h61};
        exp_bad    = '{8'h03, 8'h04, 8'h03, 8'hFF, 8'h1F};
        exp_valid  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        early_edge = '{17, 21, 17, 129, 129};
        for (int v = 0; v < 5; v++) begin
            fill_mem(8'h61);
            for (int i = 0; i < 5; i++) mem[i] = pat[v][i];
            if (v == 4) mem[31] = 8'hFF;
            exp_edge = EARLY ? early_edge[v] : 129;
            scan_once(1'b0, de);
            tests_run++;
            if (de !== exp_edge) begin
                tests_failed++;
                $display("[TB] FAIL boundary%0d_done_edge: got %0d expected %0d", v, de, exp_edge);
            end
            tests_run++;
            if (valid_flag !== exp_valid[v]) begin
                tests_failed++;
                $display("[TB] FAIL boundary%0d_valid: got %b expected %b", v, valid_flag, exp_valid[v]);
            end
            tests_run++;
            if (bad_addr !== exp_bad[v]) begin
                tests_failed++;
                $display("[TB] FAIL boundary%0d_bad_addr: got %h expected %h", v, bad_addr, exp_bad[v]);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int de;
        int errs;
        fill_mem(8'h61);
        start_flag = 1'b0;
        repeat (2) @(negedge clk);
        start_flag = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) start_flag = 1'b0;
        end
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if (done_flag !== 1'b0 || address !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL midreset_done_addr: got done=%b addr=%h expected 0 00", done_flag, address);
        end
        tests_run++;
        if (bad_addr !== 8'hFF || valid_flag !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_result: got valid=%b bad=%h expected 0 ff", valid_flag, bad_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        errs = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (done_flag !== 1'b0 || address !== 8'h00) errs++;
        end
        tests_run++;
        if (errs !== 0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_idle_hold: got %0d bad cycles expected 0", errs);
        end
        scan_once(1'b0, de);
        tests_run++;
        if (de !== 129 || valid_flag !== 1'b1 || bad_addr !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL midreset_rescan: got edge=%0d valid=%b bad=%h expected 129 1 ff",
                     de, valid_flag, bad_addr);
        end
    endtask

    task automatic test_handshake();
        int de;
        int errs;
        int exp_edge;
        fill_mem(8'h7A);
        scan_once(1'b1, de);
        tests_run++;
        if (de !== 129 || valid_flag !== 1'b1 || bad_addr !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL hold_scan: got edge=%0d valid=%b bad=%h expected 129 1 ff",
                     de, valid_flag, bad_addr);
        end
        errs = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done_flag !== 1'b1 || address !== 8'h1F) errs++;
        end
        tests_run++;
        if (errs !== 0) begin
            tests_failed++;
            $display("[TB] FAIL hold_no_retrigger: got %0d bad cycles expected 0", errs);
        end
        @(negedge clk);
        start_flag = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (done_flag !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL drop_done_falls: got %b expected 0", done_flag);
        end
        mem[7] = 8'h7B;
        exp_edge = EARLY ? 33 : 129;
        scan_once(1'b0, de);
        tests_run++;
        if (de !== exp_edge) begin
            tests_failed++;
            $display("[TB] FAIL restart_done_edge: got %0d expected %0d", de, exp_edge);
        end
        tests_run++;
        if (valid_flag !== 1'b0 || bad_addr !== 8'h07) begin
            tests_failed++;
            $display("[TB] FAIL restart_result: got valid=%b bad=%h expected 0 07", valid_flag, bad_addr);
        end
    endtask

    task automatic test_msg_len_one();
        logic [7:0] byte0 [2];
        logic       exp_valid [2];
        logic [7:0] exp_bad [2];
        int         de;
        byte0     = '{8'hFF, 8'h20};
        exp_valid = '{1'b0, 1'b1};
        exp_bad   = '{8'h00, 8'hFF};
        for (int v = 0; v < 2; v++) begin
            mem1[0] = byte0[v];
            start1 = 1'b0;
            repeat (2) @(negedge clk);
            start1 = 1'b1;
            de = -1;
            for (int e = 1; e <= 20; e++) begin
                @(posedge clk);
                #1;
                if (e == 1) start1 = 1'b0;
                if (done_flag1) begin
                    de = e;
                    break;
                end
            end
            tests_run++;
            if (de !== 5) begin
                tests_failed++;
                $display("[TB] FAIL len1_v%0d_done_edge: got %0d expected 5", v, de);
            end
            tests_run++;
            if (valid_flag1 !== exp_valid[v] || bad_addr1 !== exp_bad[v]) begin
                tests_failed++;
                $display("[TB] FAIL len1_v%0d_result: got valid=%b bad=%h expected %b %h",
                         v, valid_flag1, bad_addr1, exp_valid[v], exp_bad[v]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_all_legal();
        test_bad_byte5();
        test_boundary_chars();
        test_reset_mid_scan();
        test_handshake();
        test_msg_len_one();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
